// File: rtl/cache_bus_arbiter_pkg.sv
// Shared types for the cache bus arbiter: request/response structs and FSM state encoding.
package cache_bus_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  w_strb;
    logic [31:0] w_data;
  } cache_bus_req_t;

  typedef struct packed {
    logic        ready;
    logic        data_ok;
    logic        data_last;
    logic [31:0] r_data;
  } cache_bus_resp_t;

  localparam logic [2:0] ARB_STATE_IDLE = 3'b001;
  localparam logic [2:0] ARB_STATE_ADDR = 3'b010;
  localparam logic [2:0] ARB_STATE_DATA = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE = ARB_STATE_IDLE,
    ST_ADDR = ARB_STATE_ADDR,
    ST_DATA = ARB_STATE_DATA
  } arb_state_e;

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// Bundles the per-requester ports and the bridge-side port of the cache bus arbiter.
interface cache_bus_arbiter_if #(
  parameter int N_REQ = 2
);
  import cache_bus_arbiter_pkg::*;

  cache_bus_req_t  [N_REQ-1:0] req_i;
  cache_bus_resp_t [N_REQ-1:0] resp_o;
  cache_bus_req_t              bus_req_o;
  cache_bus_resp_t             bus_resp_i;

  // master: the environment (cache masters + bridge); slave: the arbiter itself
  modport master (output req_i, output bus_resp_i, input resp_o, input bus_req_o);
  modport slave  (input req_i, input bus_resp_i, output resp_o, output bus_req_o);

endinterface

// File: rtl/cache_bus_arbiter_grant_picker.sv
// Combinational winner search over a request vector, starting at i_start and wrapping modulo N_REQ.
module bus_grant_picker #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_any
);

  int w_idx;

  always_comb begin
    o_winner = '0;
    o_any    = 1'b0;
    w_idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = int'(i_start) + i;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      // Only in-range indices are ever compared, so non power-of-two N_REQ is safe
      for (int j = 0; j < N_REQ; j++) begin
        if (!o_any && (j == w_idx) && i_req[j]) begin
          o_any    = 1'b1;
          o_winner = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Grants the external cache bus to one requester for a whole transaction (address through last beat).
// Define CACHE_ARB_RR_EN for round-robin selection; fixed lowest-index priority otherwise.
module cache_bus_arbiter #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  cache_bus_arbiter_if.slave      bus_if,
  output logic [IDX_W-1:0]        owner_o,
  output logic                    busy_o
);
  import cache_bus_arbiter_pkg::*;

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] w_winner;
  logic [IDX_W-1:0] w_start;
  logic [N_REQ-1:0] w_req_valid;
  logic             w_any;

  always_comb begin
    w_req_valid = '0;
    for (int k = 0; k < N_REQ; k++) w_req_valid[k] = bus_if.req_i[k].valid;
  end

`ifdef CACHE_ARB_RR_EN
  logic [IDX_W-1:0] r_rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (r_state == ST_IDLE && w_any) begin
      r_rr_ptr <= (int'(w_winner) == N_REQ - 1) ? '0 : w_winner + IDX_W'(1);
    end
  end

  assign w_start = r_rr_ptr;
`else
  assign w_start = '0;
`endif

  bus_grant_picker #(.N_REQ(N_REQ)) u_picker (
    .i_req    (w_req_valid),
    .i_start  (w_start),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // NOTE: registers update with non-blocking (<=); the combinational block below uses blocking (=).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_any) r_owner <= w_winner;
    end
  end

  // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    bus_if.bus_req_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      bus_if.resp_o[k]        = '0;
      bus_if.resp_o[k].r_data = bus_if.bus_resp_i.r_data;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_any) w_state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        bus_if.bus_req_o        = bus_if.req_i[r_owner];
        bus_if.resp_o[r_owner]  = bus_if.bus_resp_i;
        if (bus_if.bus_resp_i.ready) begin
          // A single-beat response may complete in the address cycle itself
          if (bus_if.bus_resp_i.data_ok && bus_if.bus_resp_i.data_last) w_state_nxt = ST_IDLE;
          else                                                          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        bus_if.bus_req_o       = bus_if.req_i[r_owner];
        bus_if.bus_req_o.valid = 1'b0;
        bus_if.resp_o[r_owner] = bus_if.bus_resp_i;
        if (bus_if.bus_resp_i.data_ok && bus_if.bus_resp_i.data_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign owner_o = r_owner;
  assign busy_o  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: a bridge model plus a queue-free pending/pointer model of arbitration.
module tb_cache_bus_arbiter;
  import cache_bus_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] owner_o;
  logic          busy_o;

  cache_bus_arbiter_if #(.N_REQ(N)) bus_if ();

  cache_bus_arbiter #(.N_REQ(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus_if  (bus_if),
    .owner_o (owner_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  int             checks = 0;
  int             errors = 0;
  cache_bus_req_t exp_req   [N];
  cache_bus_req_t stage_req [N];
  bit             stage_set [N];
  bit             drop_set  [N];
  bit             pend      [N];
  int             rr_model = 0;
  logic [31:0]    got_q [$];

  // Inputs change only at the falling edge; outputs are sampled 1 ns later.
  task automatic begin_cycle();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (drop_set[k]) begin
        bus_if.req_i[k].valid = 1'b0;
        drop_set[k] = 1'b0;
      end
      if (stage_set[k]) begin
        bus_if.req_i[k] = stage_req[k];
        exp_req[k]      = stage_req[k];
        pend[k]         = 1'b1;
        stage_set[k]    = 1'b0;
      end
    end
  endtask

  task automatic end_cycle();
    #1;
  endtask

  task automatic stage(input int k, input cache_bus_req_t r);
    stage_req[k] = r;
    stage_set[k] = 1'b1;
  endtask

  task automatic stage_rand(input int k);
    cache_bus_req_t r;
    r.valid  = 1'b1;
    r.wr     = 1'($urandom_range(0, 1));
    r.size   = 3'($urandom_range(0, 2));
    r.addr   = $urandom;
    r.w_strb = r.wr ? 4'($urandom) : 4'h0;
    r.w_data = r.wr ? 32'($urandom) : 32'h0;
    stage(k, r);
  endtask

  // Spec-level arbitration: first pending requester found from the pointer, wrapping modulo N.
  function automatic int model_pick();
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (rr_model + i) % N;
      if (pend[idx]) begin
`ifdef CACHE_ARB_RR_EN
        rr_model = (idx + 1) % N;
`endif
        return idx;
      end
    end
    return -1;
  endfunction

  function automatic bit any_pend();
    for (int k = 0; k < N; k++) if (pend[k]) return 1'b1;
    return 1'b0;
  endfunction

  // The mandatory IDLE cycle between transactions; returns who the model says wins it.
  task automatic idle_grant(output int exp_owner);
    begin_cycle();
    bus_if.bus_resp_i = '0;
    end_cycle();
    checks++;
    if (busy_o !== 1'b0 || bus_if.bus_req_o.valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_cycle: busy=%0b bus_valid=%0b, required 0/0", busy_o, bus_if.bus_req_o.valid);
    end
    exp_owner = model_pick();
  endtask

  // Bridge side of one transaction owned by 'own', starting in its first ADDR cycle.
  task automatic do_txn(input int own, input int rdly, input int nbeats, input logic [31:0] base,
                        input bit in_addr);
    cache_bus_resp_t br;
    cache_bus_req_t  er;
    logic [2:0]      got_c, exp_c;
    int              n_exp;
    got_q.delete();
    n_exp = in_addr ? 1 : nbeats;

    for (int d = 0; d <= rdly; d++) begin
      begin_cycle();
      br        = '0;
      br.r_data = $urandom;
      br.ready  = (d == rdly);
      if (in_addr && d == rdly) begin
        br.data_ok   = 1'b1;
        br.data_last = 1'b1;
        br.r_data    = base;
      end
      bus_if.bus_resp_i = br;
      if (d == rdly) begin
        drop_set[own] = 1'b1;
        pend[own]     = 1'b0;
      end
      end_cycle();
      checks++;
      if (bus_if.bus_req_o !== exp_req[own]) begin
        errors++;
        $display("FAIL addr_passthrough: bus_req_o=%h, required %h", bus_if.bus_req_o, exp_req[own]);
      end
      checks++;
      if (owner_o !== IW'(own) || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL addr_owner: owner=%0d busy=%0b, required %0d/1", owner_o, busy_o, own);
      end
      for (int k = 0; k < N; k++) begin
        got_c = {bus_if.resp_o[k].ready, bus_if.resp_o[k].data_ok, bus_if.resp_o[k].data_last};
        exp_c = (k == own) ? {br.ready, br.data_ok, br.data_last} : 3'b000;
        checks++;
        if (got_c !== exp_c) begin
          errors++;
          $display("FAIL addr_resp_ctrl[%0d]: rdy/ok/last=%b, required %b", k, got_c, exp_c);
        end
      end
      if (bus_if.resp_o[own].data_ok === 1'b1) got_q.push_back(bus_if.resp_o[own].r_data);
    end

    if (!in_addr) begin
      for (int b = 0; b < nbeats; b++) begin
        int gaps;
        gaps = $urandom_range(0, 1);
        for (int g = 0; g <= gaps; g++) begin
          begin_cycle();
          br        = '0;
          br.r_data = $urandom;
          if (g == gaps) begin
            br.data_ok   = 1'b1;
            br.data_last = (b == nbeats - 1);
            br.r_data    = base + 32'(b);
          end
          bus_if.bus_resp_i = br;
          end_cycle();
          er       = exp_req[own];
          er.valid = 1'b0;
          checks++;
          if (bus_if.bus_req_o !== er) begin
            errors++;
            $display("FAIL data_passthrough: bus_req_o=%h, required %h", bus_if.bus_req_o, er);
          end
          checks++;
          if (owner_o !== IW'(own) || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL data_owner: owner=%0d busy=%0b, required %0d/1", owner_o, busy_o, own);
          end
          for (int k = 0; k < N; k++) begin
            got_c = {bus_if.resp_o[k].ready, bus_if.resp_o[k].data_ok, bus_if.resp_o[k].data_last};
            exp_c = (k == own) ? {br.ready, br.data_ok, br.data_last} : 3'b000;
            checks++;
            if (got_c !== exp_c) begin
              errors++;
              $display("FAIL data_resp_ctrl[%0d]: rdy/ok/last=%b, required %b", k, got_c, exp_c);
            end
          end
          if (bus_if.resp_o[own].data_ok === 1'b1) got_q.push_back(bus_if.resp_o[own].r_data);
        end
      end
    end

    checks++;
    if (got_q.size() != n_exp) begin
      errors++;
      $display("FAIL beat_count: owner %0d got %0d beats, required %0d", own, got_q.size(), n_exp);
    end else begin
      for (int b = 0; b < n_exp; b++) begin
        checks++;
        if (got_q[b] !== base + 32'(b)) begin
          errors++;
          $display("FAIL beat_data[%0d]: got %h, required %h", b, got_q[b], base + 32'(b));
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (bus_if.bus_req_o !== '0 || owner_o !== '0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: bus_req_o=%h owner=%0d busy=%0b, required all 0", tag, bus_if.bus_req_o, owner_o, busy_o);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({bus_if.resp_o[k].ready, bus_if.resp_o[k].data_ok, bus_if.resp_o[k].data_last} !== 3'b000) begin
        errors++;
        $display("FAIL %s_resp[%0d]: rdy/ok/last=%b, required 000", tag, k,
                 {bus_if.resp_o[k].ready, bus_if.resp_o[k].data_ok, bus_if.resp_o[k].data_last});
      end
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      begin_cycle();
      for (int k = 0; k < N; k++) bus_if.req_i[k] = {1'b1, 72'($urandom), 1'($urandom)};
      bus_if.bus_resp_i = {3'b111, 32'($urandom)};
      end_cycle();
      check_all_zero("reset");
    end
    begin_cycle();
    rst               = 1'b0;
    bus_if.req_i      = '0;
    bus_if.bus_resp_i = '0;
    end_cycle();
    check_all_zero("reset_release");
  endtask

  task automatic test_single_read();
    cache_bus_req_t r;
    int             e;
    r      = '0;
    r.valid = 1'b1;
    r.size  = 3'd2;
    r.addr  = 32'h1C00_0000;
    stage(0, r);
    idle_grant(e);
    do_txn(e, 2, 4, 32'hA0, 1'b0);
    idle_grant(e);
  endtask

  task automatic test_simultaneous();
    int e1, e2;
    stage_rand(0);
    stage_rand(1);
    idle_grant(e1);
    do_txn(e1, $urandom_range(0, 3), $urandom_range(1, 4), $urandom, 1'b0);
    idle_grant(e2);
    do_txn(e2, $urandom_range(0, 3), $urandom_range(1, 4), $urandom, 1'b0);
    idle_grant(e1);
  endtask

  task automatic test_round_robin();
    int e;
    int seq [4];
    stage_rand(0);
    stage_rand(1);
    for (int t = 0; t < 4; t++) begin
      idle_grant(e);
      seq[t] = e;
      do_txn(e, $urandom_range(0, 2), $urandom_range(1, 3), $urandom, 1'b0);
      if (t < 3) stage_rand(e);
    end
    for (int t = 1; t < 4; t++) begin
      checks++;
`ifdef CACHE_ARB_RR_EN
      if (seq[t] == seq[t-1]) begin
        errors++;
        $display("FAIL rr_sequence[%0d]: owner %0d repeated, required alternation", t, seq[t]);
      end
`else
      if (seq[t] != 0) begin
        errors++;
        $display("FAIL fixed_sequence[%0d]: owner %0d, required 0", t, seq[t]);
      end
`endif
    end
    for (int t = 0; t < N && any_pend(); t++) begin
      idle_grant(e);
      do_txn(e, $urandom_range(0, 2), $urandom_range(1, 3), $urandom, 1'b0);
    end
    idle_grant(e);
  endtask

  task automatic test_single_beat();
    int e;
    stage_rand($urandom_range(0, N - 1));
    idle_grant(e);
    do_txn(e, $urandom_range(0, 2), 1, $urandom, 1'b1);
    idle_grant(e);
  endtask

  task automatic test_write();
    cache_bus_req_t r;
    int             e;
    r        = '0;
    r.valid  = 1'b1;
    r.wr     = 1'b1;
    r.size   = 3'd2;
    r.addr   = 32'h1C00_0040;
    r.w_strb = 4'hF;
    r.w_data = 32'hDEAD_BEEF;
    stage(1, r);
    idle_grant(e);
    stage_rand(0);
    do_txn(e, 2, 1, $urandom, 1'b0);
    idle_grant(e);
    do_txn(e, 1, 2, $urandom, 1'b0);
    idle_grant(e);
  endtask

  task automatic test_reset_mid();
    int e;
    stage_rand(0);
    idle_grant(e);
    begin_cycle();
    bus_if.bus_resp_i = {3'b100, 32'($urandom)};
    drop_set[e] = 1'b1;
    pend[e]     = 1'b0;
    end_cycle();
    for (int b = 0; b < 2; b++) begin
      begin_cycle();
      bus_if.bus_resp_i = {3'b010, 32'($urandom)};
      end_cycle();
    end
    begin_cycle();
    rst               = 1'b1;
    bus_if.bus_resp_i = {3'b011, 32'($urandom)};
    end_cycle();
    rr_model = 0;
    stage_rand(1);
    begin_cycle();
    rst               = 1'b0;
    bus_if.bus_resp_i = {3'b111, 32'($urandom)};
    end_cycle();
    check_all_zero("reset_mid");
    e = model_pick();
    do_txn(e, $urandom_range(0, 2), $urandom_range(1, 4), $urandom, 1'b0);
    idle_grant(e);
  endtask

  task automatic test_random();
    int e;
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < N; k++)
        if (!pend[k] && $urandom_range(0, 1) == 1) stage_rand(k);
      if (!any_pend() && !stage_set[0] && !stage_set[1]) stage_rand($urandom_range(0, N - 1));
      idle_grant(e);
      for (int k = 0; k < N; k++)
        if (!pend[k] && k != e && $urandom_range(0, 2) == 0) stage_rand(k);
      do_txn(e, $urandom_range(0, 3), $urandom_range(1, 4), $urandom, ($urandom_range(0, 3) == 0));
    end
    for (int t = 0; t < N && any_pend(); t++) begin
      idle_grant(e);
      do_txn(e, $urandom_range(0, 3), $urandom_range(1, 4), $urandom, 1'b0);
    end
    idle_grant(e);
  endtask

  initial begin
    rst               = 1'b1;
    bus_if.req_i      = '0;
    bus_if.bus_resp_i = '0;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_round_robin();
    test_single_beat();
    test_write();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_bus_arbiter.md
# cache_bus_arbiter

Shares one external cache bus between N cache requesters (icache refill, dcache refill/writeback, uncached ports). Each requester sees a private `cache_bus_req_t`/`cache_bus_resp_t` pair identical to a direct bus connection. The block sits between the cache masters and the AXI bridge. It grants one whole transaction at a time (address phase through last beat) and never interleaves beats of different owners.

## Interface
Parameters:
- `N_REQ`, default 2. Number of requesters; 2..8. Index 0 is icache, 1 is dcache.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_i`  in  `cache_bus_req_t [N_REQ-1:0]`  per-requester bus requests.
- `resp_o`  out  `cache_bus_resp_t [N_REQ-1:0]`  per-requester bus responses.
- `bus_req_o`  out  `cache_bus_req_t`  request to the bus bridge.
- `bus_resp_i`  in  `cache_bus_resp_t`  response from the bus bridge.
- `owner_o`  out  `$clog2(N_REQ)`  index of the current owner (debug/perf).
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- **FSM states (one-hot):** IDLE, ADDR, DATA.
- **IDLE**
  - If any `req_i[k].valid` is high, pick a winner, register it in `owner_q`, and go to ADDR next cycle.
  - Otherwise stay in IDLE.
- **ADDR**
  - `bus_req_o` = `req_i[owner_q]` (all fields passed through).
  - `resp_o[owner_q]` = `bus_resp_i`.
  - On `bus_resp_i.ready`, go to DATA.
- **DATA**
  - Same pass-through as ADDR, except `bus_req_o.valid` is forced to 0.
  - On `bus_resp_i.data_ok & bus_resp_i.data_last`, go to IDLE. This end condition applies to reads and writes alike.
- **Non-owners**
  - `resp_o[k]`: `ready`, `data_ok` and `data_last` are 0.
  - `r_data` is broadcast, which is harmless because it is qualified by `data_ok`.
- **Winner selection:** fixed priority (lowest index wins) unless the round-robin feature is compiled in (see Configuration).
- **Protocol rule for masters:** once `valid` is asserted, it stays asserted with stable fields until `ready`. The arbiter does not re-check the owner's `valid` after grant, so the grant is held even if the master drops `valid`.
- **Width rules**
  - `owner_q` is `$clog2(N_REQ)` bits.
  - With `N_REQ` not a power of two, out-of-range indices are never produced.

## Timing
- **Reset:** the state goes to IDLE, `owner_q` = 0 and the round-robin pointer = 0. All outputs are 0: `bus_req_o` all fields, every `resp_o` control field, `owner_o`, `busy_o`.
- **Grant latency:** request seen in IDLE at cycle t gives `bus_req_o.valid` at t+1. A request that arrives while the bus is busy waits for the IDLE cycle.
- **Turnaround:** the last beat at cycle t puts the FSM in IDLE at t+1, and the next owner's `bus_req_o.valid` appears at t+2. This is a one-cycle bubble between transactions and is intended.
- **Simultaneous requests in IDLE:** exactly one winner. Losers see `ready=0` and keep waiting.
- **`ready` and `data_ok & data_last` in the same ADDR cycle:** the single-beat response is passed to the owner and the FSM goes directly to IDLE.
- **Reset mid-transaction:** the FSM aborts to IDLE and the outputs return to 0. The bridge is reset by the same `rst` and must drop its transaction too.
- **Combinational paths:** `req_i` → `bus_req_o` and `bus_resp_i` → `resp_o` within the same cycle. There are no other combinational paths.

## Configuration
- **`CACHE_ARB_RR_EN` defined:**
  - Round-robin selection: search starts at `rr_ptr` and wraps modulo `N_REQ`.
  - On each grant, `rr_ptr` = winner+1 (wraps to 0 after `N_REQ-1`).
- **Not defined:**
  - Fixed priority, lowest index wins.
  - `rr_ptr` is not instantiated.

## Structure
- **Shared package (`common.svh` package):**
  - `cache_bus_req_t`, `cache_bus_resp_t` (existing).
  - New FSM state localparams `ARB_STATE_IDLE`/`ARB_STATE_ADDR`/`ARB_STATE_DATA`.
- **One sub-module, `bus_grant_picker`:**
  - Combinational.
  - Inputs: request vector and start pointer. Outputs: winner index and `any` flag.
  - Fixed priority is the case with start pointer 0.

## Test plan
- **Single read:** `req_i[0]` read at addr 0x1C000000; bridge gives `ready` after 2 cycles, then 4 beats 0xA0..0xA3 with last on the 4th. Required: `resp_o[0]` sees exactly these beats, `resp_o[1]` sees no `data_ok`, and `busy_o` falls the cycle after the last beat.
- **Simultaneous requests, fixed priority:** requesters 0 and 1 assert `valid` in the same cycle. Required: owner 0 completes first, and requester 1's `bus_req_o.valid` appears exactly 2 cycles after owner 0's last beat.
- **`CACHE_ARB_RR_EN`:** requesters 0 and 1 both request continuously for 4 transactions. Required: owner sequence 0,1,0,1.
- **Single beat in ADDR:** an uncached 1-beat read where `ready`, `data_ok` and `data_last` all arrive in the same ADDR cycle. Required: owner gets the data and the FSM is in IDLE the next cycle.
- **Write passthrough:** requester 1 writes `w_data`=0xDEADBEEF with strobe 0xF. Required: `bus_req_o` carries these fields unchanged, and requester 0 issuing a request mid-transfer sees `ready=0` until the grant.
- **Reset mid-DATA:** assert `rst` after beat 2 of 4. Required: all outputs are 0 the next cycle, and a new request after reset gets a grant with 1-cycle latency.
